// File: rtl/par2ser_pkg.sv
// par2ser_pkg: shared definitions for the parallel-to-serial transmitter.
//   state_t   - transmitter FSM state (IDLE, SHIFT, PARITY), 2-bit encoding
//   BUF_DEPTH - number of words the input buffer can hold
//   clogb2    - ceiling log2 (minimum 1), sizes the bit counter
package par2ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 2;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/par2ser_if.sv
// par2ser_if: word handshake between a producer and the transmitter.
//   din       - parallel word
//   din_valid - producer holds a word
//   din_ready - transmitter can take a word
// Handshake: a word moves on a rising fclk edge where din_valid && din_ready;
// the producer keeps din stable while din_valid is high and not yet accepted.
interface par2ser_if #(parameter int N = 8);
    logic [N-1:0] din;
    logic         din_valid;
    logic         din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/par2ser_buf.sv
// par2ser_buf: 2-entry FIFO holding words waiting to be serialized.
//   fclk, rstn - clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata - write a word (caller guarantees not full)
//   pop        - drop the head word (caller guarantees not empty)
//   head       - oldest stored word
//   count      - occupancy 0..2
module par2ser_buf
    import par2ser_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         fclk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [BUF_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge fclk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge fclk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/par2ser_tx.sv
// par2ser_tx: parallel-to-serial transmitter. Words arriving on in_if are
// buffered (2 deep) and shifted out one bit per fclk, gap-free between
// consecutive frames, with ser_sync marking each frame's first bit.
//   fclk, rstn  - clock, asynchronous active-low reset
//   in_if       - par2ser_if slave: din / din_valid / din_ready
//   ser_out     - serial bit (IDLE_LEVEL when no frame), registered
//   ser_sync    - first data bit of a frame, registered
//   ser_busy    - a frame bit is on ser_out, registered
//   frame_done  - last bit of a frame (parity bit when enabled), registered
//   dbg_state   - current FSM state for observation
// Build option: define SER_PARITY_EN to append an even-parity bit per frame.
module par2ser_tx
    import par2ser_pkg::*;
#(
    parameter int   N          = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic   fclk,
    input  logic   rstn,
    par2ser_if.slave in_if,
    output logic   ser_out,
    output logic   ser_sync,
    output logic   ser_busy,
    output logic   frame_done,
    output state_t dbg_state
);

    localparam int              CNT_W = clogb2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [1:0]       count;
    logic [N-1:0]     head;
    logic             ready;
    logic             push;
    logic             pop;

    state_t           state, state_next;
    logic [N-1:0]     shreg, shreg_d;
    logic [CNT_W-1:0] bit_cnt, cnt_d;
    logic             want_next;
    logic             out_d, sync_d, busy_d, done_d;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    assign ready           = (count != 2'(BUF_DEPTH));
    assign in_if.din_ready = ready;
    assign push            = in_if.din_valid && ready;
    assign dbg_state       = state;

    par2ser_buf #(.W(N)) u_buf (
        .fclk  (fclk),
        .rstn  (rstn),
        .push  (push),
        .wdata (in_if.din),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge fclk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            ser_out    <= IDLE_LEVEL;
            ser_sync   <= 1'b0;
            ser_busy   <= 1'b0;
            frame_done <= 1'b0;
`ifdef SER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            shreg      <= shreg_d;
            bit_cnt    <= cnt_d;
            ser_out    <= out_d;
            ser_sync   <= sync_d;
            ser_busy   <= busy_d;
            frame_done <= done_d;
`ifdef SER_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        shreg_d    = shreg;
        cnt_d      = bit_cnt;
        want_next  = 1'b0;
        out_d      = IDLE_LEVEL;
        sync_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
`ifdef SER_PARITY_EN
        par_d      = par_q;
`endif
        case (state)
            IDLE: want_next = 1'b1;
            SHIFT: begin
                // The outgoing bit always sits at the shift-out end of shreg.
                out_d   = MSB_FIRST ? shreg[N-1] : shreg[0];
                sync_d  = (bit_cnt == '0);
                busy_d  = 1'b1;
                shreg_d = MSB_FIRST ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};
                if (bit_cnt == LAST) begin
`ifdef SER_PARITY_EN
                    state_next = PARITY;
`else
                    done_d    = 1'b1;
                    want_next = 1'b1;
`endif
                end else begin
                    cnt_d = bit_cnt + CNT_W'(1);
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                out_d     = par_q;
                busy_d    = 1'b1;
                done_d    = 1'b1;
                want_next = 1'b1;
            end
`endif
            default: state_next = IDLE;
        endcase

        // Reload-or-idle: taking the next word on the last bit keeps frames
        // back-to-back with no idle cycle in between.
        if (want_next) begin
            if (count != 2'd0) begin
                pop        = 1'b1;
                shreg_d    = head;
                cnt_d      = '0;
                state_next = SHIFT;
`ifdef SER_PARITY_EN
                par_d      = ^head;
`endif
            end else begin
                state_next = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_par2ser_tx.sv
// tb_par2ser_tx: directed self-checking bench for par2ser_tx.
// Main instance: N=8, MSB first, idle level 0. Second instance: LSB first.
module tb_par2ser_tx;
    import par2ser_pkg::*;

    localparam int N = 8;
`ifdef SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = N + PAR;

    // clock / reset
    logic fclk = 1'b0;
    logic rstn = 1'b0;
    always #5 fclk = ~fclk;

    par2ser_if #(.N(N)) m_if ();
    par2ser_if #(.N(N)) l_if ();

    logic   m_ser_out, m_ser_sync, m_ser_busy, m_frame_done;
    logic   l_ser_out, l_ser_sync, l_ser_busy, l_frame_done;
    state_t m_state, l_state;

    par2ser_tx #(.N(N), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut (
        .fclk       (fclk),
        .rstn       (rstn),
        .in_if      (m_if.slave),
        .ser_out    (m_ser_out),
        .ser_sync   (m_ser_sync),
        .ser_busy   (m_ser_busy),
        .frame_done (m_frame_done),
        .dbg_state  (m_state)
    );

    par2ser_tx #(.N(N), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .fclk       (fclk),
        .rstn       (rstn),
        .in_if      (l_if.slave),
        .ser_out    (l_ser_out),
        .ser_sync   (l_ser_sync),
        .ser_busy   (l_ser_busy),
        .frame_done (l_frame_done),
        .dbg_state  (l_state)
    );

    // scoreboard
    int           compared   = 0;
    int           mismatched = 0;
    logic [N-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    // Receive one frame on the main instance, first bit appears after the next edge.
    task automatic rx_frame(input string tag);
        logic [N-1:0] w;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
            return;
        end
        w = exp_q.pop_front();
        for (int i = 0; i < N; i++) begin
            tick();
            chk($sformatf("%s_bit%0d", tag, i), 32'(m_ser_out), 32'(w[N-1-i]));
            chk($sformatf("%s_sync%0d", tag, i), 32'(m_ser_sync), 32'(i == 0));
            chk($sformatf("%s_done%0d", tag, i), 32'(m_frame_done), 32'((i == N-1) && (PAR == 0)));
            chk($sformatf("%s_busy%0d", tag, i), 32'(m_ser_busy), 32'd1);
        end
        if (PAR == 1) begin
            tick();
            chk({tag, "_parity"}, 32'(m_ser_out), 32'(^w));
            chk({tag, "_parity_done"}, 32'(m_frame_done), 32'd1);
            chk({tag, "_parity_sync"}, 32'(m_ser_sync), 32'd0);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ser_out"}, 32'(m_ser_out), 32'd0);
        chk({tag, "_busy"}, 32'(m_ser_busy), 32'd0);
        chk({tag, "_done"}, 32'(m_frame_done), 32'd0);
    endtask

    // backpressure capture
    logic [N-1:0] bp_words[5];
    logic         cap_bits[$];
    logic         cap_sync[$];

    initial begin
        int           idx;
        int           gaps;
        int           sync_err;
        int           bad;
        logic         xfer;
        logic [N-1:0] w;

        m_if.din = '0;
        m_if.din_valid = 1'b0;
        l_if.din = '0;
        l_if.din_valid = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        chk("rst_ser_out", 32'(m_ser_out), 32'd0);
        chk("rst_sync", 32'(m_ser_sync), 32'd0);
        chk("rst_busy", 32'(m_ser_busy), 32'd0);
        chk("rst_done", 32'(m_frame_done), 32'd0);
        chk("rst_ready", 32'(m_if.din_ready), 32'd1);
        chk("rst_state", 32'(m_state), 32'(IDLE));
        chk("rst_lsb_state", 32'(l_state), 32'(IDLE));
        rstn = 1'b1;
        tick();

        // ---- single word 8'hA5 ----
        m_if.din = 8'hA5;
        m_if.din_valid = 1'b1;
        exp_q.push_back(8'hA5);
        chk("a5_ready", 32'(m_if.din_ready), 32'd1);
        tick();                               // edge t: accepted
        m_if.din_valid = 1'b0;
        chk_idle("a5_t0");
        tick();                               // edge t+1: FSM loads
        chk_idle("a5_t1");
        chk("a5_t1_sync", 32'(m_ser_sync), 32'd0);
        rx_frame("a5");                       // edges t+2 .. t+9
        tick();
        chk_idle("a5_after");

        // ---- back-to-back 8'h3C, 8'hC3 ----
        m_if.din = 8'h3C;
        m_if.din_valid = 1'b1;
        exp_q.push_back(8'h3C);
        tick();
        m_if.din = 8'hC3;
        exp_q.push_back(8'hC3);
        chk("b2b_ready2", 32'(m_if.din_ready), 32'd1);
        tick();
        m_if.din_valid = 1'b0;
        rx_frame("b2b_3c");
        rx_frame("b2b_c3");
        tick();
        chk_idle("b2b_after");

        // ---- backpressure: 5 words with valid held high ----
        bp_words[0] = 8'h11; bp_words[1] = 8'h2E; bp_words[2] = 8'hD3;
        bp_words[3] = 8'h4B; bp_words[4] = 8'hF0;
        idx = 0;
        gaps = 0;
        m_if.din = bp_words[0];
        m_if.din_valid = 1'b1;
        for (int cyc = 0; cyc < 200 && cap_bits.size() < 5*FL; cyc++) begin
            xfer = m_if.din_valid && m_if.din_ready;
            tick();
            if (xfer) begin
                exp_q.push_back(bp_words[idx]);
                idx++;
                if (idx == 3) chk("bp_ready_drop", 32'(m_if.din_ready), 32'd0);
                if (idx < 5) m_if.din = bp_words[idx];
                else m_if.din_valid = 1'b0;
            end
            if (m_ser_busy) begin
                cap_bits.push_back(m_ser_out);
                cap_sync.push_back(m_ser_sync);
            end else if (cap_bits.size() > 0) begin
                gaps++;
            end
        end
        chk("bp_xfers", 32'(idx), 32'd5);
        chk("bp_nbits", 32'(cap_bits.size()), 32'(5*FL));
        chk("bp_gaps", 32'(gaps), 32'd0);
        if (cap_bits.size() == 5*FL) begin
            sync_err = 0;
            for (int k = 0; k < 5*FL; k++)
                if (cap_sync[k] !== ((k % FL) == 0)) sync_err++;
            chk("bp_sync_pattern", 32'(sync_err), 32'd0);
            for (int f = 0; f < 5; f++) begin
                w = '0;
                for (int i = 0; i < N; i++) w = {w[N-2:0], cap_bits[f*FL + i]};
                if (exp_q.size() > 0) chk($sformatf("bp_word%0d", f), 32'(w), 32'(exp_q.pop_front()));
                if (PAR == 1) chk($sformatf("bp_par%0d", f), 32'(cap_bits[f*FL + N]), 32'(^w));
            end
        end
        exp_q.delete();
        tick();
        chk_idle("bp_after");

        // ---- 8'h07 (parity bit 1 when enabled) ----
        m_if.din = 8'h07;
        m_if.din_valid = 1'b1;
        exp_q.push_back(8'h07);
        tick();
        m_if.din_valid = 1'b0;
        tick();
        rx_frame("p07");
        tick();
        chk_idle("p07_after");

        // ---- reset mid-frame: 8'hFF sending, 8'h5A buffered ----
        m_if.din = 8'hFF;
        m_if.din_valid = 1'b1;
        tick();
        m_if.din = 8'h5A;
        tick();
        m_if.din_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();   // bits 0..3 of 8'hFF
        chk("mid_bit3", 32'(m_ser_out), 32'd1);
        chk("mid_busy", 32'(m_ser_busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_ser_out", 32'(m_ser_out), 32'd0);
        chk("mid_rst_busy", 32'(m_ser_busy), 32'd0);
        chk("mid_rst_ready", 32'(m_if.din_ready), 32'd1);
        chk("mid_rst_sync", 32'(m_ser_sync), 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (m_ser_busy !== 1'b0 || m_ser_out !== 1'b0) bad++;
        end
        chk("mid_quiet_after_release", 32'(bad), 32'd0);
        m_if.din = 8'h81;
        m_if.din_valid = 1'b1;
        exp_q.push_back(8'h81);
        tick();
        m_if.din_valid = 1'b0;
        tick();
        rx_frame("recover81");
        tick();
        chk_idle("recover_after");

        // ---- LSB-first instance: 8'h01 ----
        l_if.din = 8'h01;
        l_if.din_valid = 1'b1;
        tick();
        l_if.din_valid = 1'b0;
        tick();
        chk("lsb_pre", 32'(l_ser_busy), 32'd0);
        for (int i = 0; i < N; i++) begin
            tick();
            chk($sformatf("lsb_bit%0d", i), 32'(l_ser_out), 32'(i == 0));
            chk($sformatf("lsb_sync%0d", i), 32'(l_ser_sync), 32'(i == 0));
        end
        chk("lsb_done", 32'(l_frame_done), 32'(PAR == 0));
        if (PAR == 1) begin
            tick();
            chk("lsb_parity", 32'(l_ser_out), 32'd1);
            chk("lsb_parity_done", 32'(l_frame_done), 32'd1);
        end
        tick();
        chk("lsb_after_busy", 32'(l_ser_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
